mram_bist: RTL
==============

// Module: mram_bist
// PURPOSE
//  Initiator side of the Mram port: a built-in self-test controller driving addr/data_in/wr/cs/rd.
//  On start it runs a two-pass write/read-back test over the whole array and reports pass/fail.
//  It also reports the error count and the first failing address.
//  Sits between the system start/status logic and one Mram instance.
// PARAMETERS
//  ADDR_W  4   address width; must match the Mram addr_size
//  DATA_W  8   word width; must match the Mram word_size
//  DEPTH   16  words tested, addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W
//  SEED    0   pattern offset, DATA_W bits
//  ERR_W   4   error counter width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  busy       out  1       high from the cycle after start until DONE is entered
//  done       out  1       high in DONE, held until the next accepted start or rst
//  pass       out  1       done && err_count==0
//  err_count  out  ERR_W   saturating mismatch count
//  fail_addr  out  ADDR_W  address of the first mismatch; 0 if none
//  mem_addr   out  ADDR_W  to Mram addr
//  mem_wdata  out  DATA_W  to Mram data_in
//  mem_rdata  in   DATA_W  from Mram data_out (combinational read)
//  mem_wr     out  1       to Mram wr
//  mem_cs     out  1       to Mram cs
//  mem_rd     out  1       to Mram rd
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, address counter 0.
//  All outputs are registered.
//  pat(a) = (2*a + SEED) mod 2**DATA_W, computed in DATA_W+1 bits and then truncated.
//  Pass 0 writes and checks pat(a). Pass 1 writes and checks ~pat(a).
//  States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE -> (start) WR0.
//  In IDLE and DONE, start=1 clears err_count/fail_addr/done and enters WR0 with addr 0.
//  WRx: 2 cycles per address because the array write is level-sensitive.
//   - Setup cycle: cs=1, wr=0, addr/wdata valid.
//   - Strobe cycle: wr=1 with addr/wdata unchanged.
//   - After the strobe for DEPTH-1: addr returns to 0 and the FSM moves to the next state.
//  RDx: 1 cycle per address, cs=1, rd=1, wr=0.
//   - mem_rdata is compared with the expected word at the clock edge ending that cycle.
//   - Mismatch: err_count += 1, saturating at 2**ERR_W-1.
//   - On the first mismatch only, fail_addr <= addr.
//  Run length: 6*DEPTH cycles from the accepted start to DONE entry (96 for DEPTH=16).
//  In IDLE and DONE, mem_cs/mem_wr/mem_rd are 0 and mem_addr/mem_wdata hold 0.
//  start while busy is ignored. start in the same cycle as rst is ignored; rst wins.
//  rst mid-run: next cycle is IDLE with all outputs 0. Array contents are undefined for the next run.
//  Address wrap: the counter never exceeds DEPTH-1; the terminal compare uses DEPTH-1, not 2**ADDR_W-1.
// STRUCTURE
//  Package mram_bist_pkg holds:
//   - state encoding localparams (IDLE, WR0, RD0, WR1, RD1, DONE)
//   - the pat() function
//   - the PASS_INV phase flag constant
//  One sub-module, mram_bist_agen, holds:
//   - the address counter and write setup/strobe phase bit
//   - the last-address flag
//   - the expected-data output (pat or ~pat)
//  The FSM, comparator and status registers stay in mram_bist.
// TESTING  (DEPTH=16, SEED=0, ERR_W=4, bench instantiates Mram)
//  1. rst, then 1-cycle start -> done=1 exactly 96 cycles later; pass=1, err_count=0, fail_addr=0.
//  2. Bit 7 of word 5 forced to 0 -> pass0 word 0x0A reads OK; pass1 expects 0xF5, reads 0x75
//     -> err_count=1, fail_addr=5, pass=0.
//  3. mem_rdata forced to 0x00 -> 31 mismatches (addr 0 matches in pass0)
//     -> err_count saturates at 15, fail_addr=1.
//  4. rst in cycle 10 of WR0 -> next cycle all outputs 0, busy=0; a later start gives pass=1 after 96 cycles.
//  5. start pulsed at cycles 5 and 50 of a run -> both ignored, done at cycle 96.
//     start in DONE -> done clears, new run begins.
//  6. SEED=3 -> the strobe for addr 15 in WR0 carries mem_wdata=0x21; in WR1 it carries 0xDE.

Source files
------------

// File: rtl/mram_bist_pkg.sv
// Shared state encoding and test-pattern helper for the Mram BIST controller.
package mram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR0  = 3'd1,
      RD0  = 3'd2,
      WR1  = 3'd3,
      RD1  = 3'd4,
      DONE = 3'd5
   } state_t;

   // Second pass uses the bitwise inverse of the base pattern.
   localparam logic PASS_INV = 1'b1;

   // Callers truncate to DATA_W, which gives the mod 2**DATA_W result.
   function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] seed);
      logic [32:0] s;
      s = {a, 1'b0} + {1'b0, seed};
      return s[31:0];
   endfunction

endpackage

// File: rtl/mram_bist_agen.sv
// Address sequencer: DEPTH-wrapping counter, write setup/strobe phase, expected word.
// Zero latency on exp_data/last (decoded from registered addr); advances only when step=1.
// No backpressure: the FSM owns pacing through step/wr_mode.
module mram_bist_agen
   import mram_bist_pkg::*;
#(
   parameter int                ADDR_W = 4,
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 16,
   parameter logic [DATA_W-1:0] SEED   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   input  logic              wr_mode,
   input  logic              inv,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_nxt,
   output logic              phase,
   output logic              last,
   output logic [DATA_W-1:0] exp_data
);

   logic              phase_nxt;
   logic [DATA_W-1:0] base;

   assign last     = (addr == ADDR_W'(DEPTH - 1));
   assign base     = DATA_W'(pat(32'(addr), 32'(SEED)));
   assign exp_data = inv ? ~base : base;

   // Writes spend a setup and a strobe cycle per address; reads take one.
   always_comb begin
      addr_nxt  = addr;
      phase_nxt = phase;
      if (clear) begin
         addr_nxt  = '0;
         phase_nxt = 1'b0;
      end else if (step) begin
         if (wr_mode && !phase) begin
            phase_nxt = 1'b1;
         end else begin
            phase_nxt = 1'b0;
            addr_nxt  = last ? '0 : addr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr  <= '0;
         phase <= 1'b0;
      end else begin
         addr  <= addr_nxt;
         phase <= phase_nxt;
      end
   end

endmodule

// File: rtl/mram_bist.sv
// Two-pass write/read-back BIST for one Mram; reports pass, error count, first failing address.
// Latency: 6*DEPTH cycles from accepted start to done; all outputs registered.
// No backpressure: start is only accepted in IDLE/DONE, ignored while busy.
module mram_bist
   import mram_bist_pkg::*;
#(
   parameter int                ADDR_W = 4,
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 16,
   parameter logic [DATA_W-1:0] SEED   = '0,
   parameter int                ERR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wr,
   output logic              mem_cs,
   output logic              mem_rd
);

   state_t            state;
   logic              wr_st, rd_st, idle_st, inv, phase, last, mism;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [DATA_W-1:0] exp_data;
   logic [ERR_W-1:0]  err_nxt;

   function automatic logic [DATA_W-1:0] word(input logic i, input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] p;
      p = DATA_W'(pat(32'(a), 32'(SEED)));
      return i ? ~p : p;
   endfunction

   assign wr_st   = (state == WR0) || (state == WR1);
   assign rd_st   = (state == RD0) || (state == RD1);
   assign idle_st = (state == IDLE) || (state == DONE);
   assign inv     = ((state == WR1) || (state == RD1)) ? PASS_INV : !PASS_INV;
   assign mism    = rd_st && (mem_rdata != exp_data);
   assign err_nxt = (mism && (err_count != '1)) ? err_count + 1'b1 : err_count;
   assign mem_addr = addr;

   mram_bist_agen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SEED   (SEED)
   ) u_agen (
      .clk      (clk),
      .rst      (rst),
      .clear    (idle_st),
      .step     (wr_st || rd_st),
      .wr_mode  (wr_st),
      .inv      (inv),
      .addr     (addr),
      .addr_nxt (addr_nxt),
      .phase    (phase),
      .last     (last),
      .exp_data (exp_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
         mem_cs    <= 1'b0;
         mem_rd    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= WR0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_addr <= '0;
                  mem_cs    <= 1'b1;
                  mem_wdata <= word(!PASS_INV, '0);
               end
            end
            WR0, WR1: begin
               if (!phase) begin
                  mem_wr <= 1'b1;
               end else begin
                  mem_wr <= 1'b0;
                  if (last) begin
                     if (state == WR0) state <= RD0;
                     else              state <= RD1;
                     mem_rd    <= 1'b1;
                     mem_wdata <= '0;
                  end else begin
                     mem_wdata <= word(inv, addr_nxt);
                  end
               end
            end
            RD0, RD1: begin
               err_count <= err_nxt;
               // err_count saturates rather than wrapping, so zero means no earlier miss.
               if (mism && (err_count == '0)) fail_addr <= addr;
               if (last) begin
                  mem_rd <= 1'b0;
                  if (state == RD0) begin
                     state     <= WR1;
                     mem_wdata <= word(PASS_INV, '0);
                  end else begin
                     state  <= DONE;
                     mem_cs <= 1'b0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     pass   <= (err_nxt == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
